motion_sequencer: RTL and testbench

// Timed motor-command sequencer between the colour classifier and the dual H-bridge driver.

---
 rtl/motion_sequencer.sv | 149 ++++++++++++++
 tb/tb_motion_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_sequencer.sv
// Timed motor-command sequencer: one command per handshake drives the dual H-bridge
// for a per-command duration with PWM enables, pausing while an obstacle is present.
module motion_sequencer #(
    parameter int DUR_W     = 26,
    parameter int DUR_FWD   = 20000000,
    parameter int DUR_TURN  = 20000000,
    parameter int DUR_STOP  = 20000000,
    parameter int PWM_W     = 8,
    parameter int DUTY_FWD  = 255,
    parameter int DUTY_TURN = 192,
    parameter int CLEAR_CYC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       proximity,
    output logic       e1,
    output logic       e2,
    output logic       as1,
    output logic       as2,
    output logic       bs1,
    output logic       bs2,
    output logic       busy,
    output logic       blocked
);

    localparam int CLR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
    localparam longint DUR_LIMIT = longint'(1) << DUR_W;
    localparam logic [1:0] CMD_LEFT  = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    generate
        if (DUR_FWD < 1 || DUR_TURN < 1 || DUR_STOP < 1 || CLEAR_CYC < 1 ||
            longint'(DUR_FWD) >= DUR_LIMIT || longint'(DUR_TURN) >= DUR_LIMIT ||
            longint'(DUR_STOP) >= DUR_LIMIT) begin : g_param_check
            $error("motion_sequencer: duration/clear parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, BLOCKED} state_t;

    state_t           state, state_nx;
    logic [1:0]       cmd_q, cmd_nx;
    logic [DUR_W-1:0] rem, rem_nx;
    logic [CLR_W-1:0] clr_cnt, clr_nx;
    logic [PWM_W-1:0] pwm_cnt, pwm_nx;
    logic             drive;
    logic [3:0]       dir_nx;
    logic             en_nx;
    logic [PWM_W-1:0] duty;

    function automatic logic [DUR_W-1:0] dur_m1(input logic [1:0] c);
        case (c)
            CMD_FWD:  return DUR_W'(DUR_FWD - 1);
            CMD_STOP: return DUR_W'(DUR_STOP - 1);
            default:  return DUR_W'(DUR_TURN - 1);
        endcase
    endfunction

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = (state == IDLE) & ~proximity & ~reset;
    assign pwm_nx    = pwm_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cmd_nx   = cmd_q;
        rem_nx   = rem;
        clr_nx   = clr_cnt;
        drive    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && !proximity) begin
                    state_nx = RUN;
                    cmd_nx   = cmd;
                    rem_nx   = dur_m1(cmd);
                    drive    = 1'b1;
                end
            end
            RUN: begin
                if (proximity) begin
                    state_nx = BLOCKED;
                    clr_nx   = '0;
                end else if (rem == '0) begin
                    state_nx = IDLE;
                end else begin
                    rem_nx = rem - 1'b1;
                    drive  = 1'b1;
                end
            end
            BLOCKED: begin
                if (proximity) begin
                    clr_nx = '0;
                end else if (clr_cnt == CLR_W'(CLEAR_CYC - 1)) begin
                    state_nx = RUN;
                    drive    = 1'b1;
                end else begin
                    clr_nx = clr_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dir_nx = 4'b0000;
        duty   = (cmd_nx == CMD_FWD) ? PWM_W'(DUTY_FWD) : PWM_W'(DUTY_TURN);
        if (drive) begin
            case (cmd_nx)
                CMD_FWD:   dir_nx = 4'b1010;
                CMD_LEFT:  dir_nx = 4'b1110;
                CMD_RIGHT: dir_nx = 4'b1011;
                default:   dir_nx = 4'b0000;
            endcase
        end
        // Enables are registered against the PWM count they will be seen with.
        en_nx = drive && (cmd_nx != CMD_STOP) && (pwm_nx < duty);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cmd_q   <= '0;
            rem     <= '0;
            clr_cnt <= '0;
            pwm_cnt <= '0;
            {as2, as1, bs2, bs1} <= 4'b0000;
            e1      <= 1'b0;
            e2      <= 1'b0;
            busy    <= 1'b0;
            blocked <= 1'b0;
        end else begin
            state   <= state_nx;
            cmd_q   <= cmd_nx;
            rem     <= rem_nx;
            clr_cnt <= clr_nx;
            pwm_cnt <= pwm_nx;
            {as2, as1, bs2, bs1} <= dir_nx;
            e1      <= en_nx;
            e2      <= en_nx;
            busy    <= (state_nx != IDLE);
            blocked <= (state_nx == BLOCKED);
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Randomised and directed checks of motion_sequencer against a cycle-level
// reference model built from the command/timer/proximity rules.
module tb_motion_sequencer;

    localparam int DUR_FWD   = 10;
    localparam int DUR_TURN  = 6;
    localparam int DUR_STOP  = 4;
    localparam int DUTY_FWD  = 7;
    localparam int DUTY_TURN = 4;
    localparam int CLEAR_CYC = 3;
    localparam logic [1:0] C_LEFT = 2'b00, C_FWD = 2'b01, C_RIGHT = 2'b10, C_STOP = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       proximity;
    logic       cmd_ready, e1, e2, as1, as2, bs1, bs2, busy, blocked;

    motion_sequencer #(
        .DUR_W(26), .DUR_FWD(DUR_FWD), .DUR_TURN(DUR_TURN), .DUR_STOP(DUR_STOP),
        .PWM_W(3), .DUTY_FWD(DUTY_FWD), .DUTY_TURN(DUTY_TURN), .CLEAR_CYC(CLEAR_CYC)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .proximity(proximity),
        .e1(e1), .e2(e2), .as1(as1), .as2(as2), .bs1(bs1), .bs2(bs2),
        .busy(busy), .blocked(blocked)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 moving, 2 paused by obstacle.
    int         m_mode, m_rem, m_clr, m_pwm;
    logic [1:0] m_cmd;

    logic [8:0] obs;
    assign obs = {cmd_ready, busy, blocked, e1, e2, as2, as1, bs2, bs1};

    function automatic int dur_of(input logic [1:0] c);
        if (c == C_FWD) return DUR_FWD;
        if (c == C_STOP) return DUR_STOP;
        return DUR_TURN;
    endfunction

    function automatic logic [8:0] expect_vec();
        logic [3:0] pat;
        logic       en;
        logic       rdy;
        pat = 4'b0000;
        en  = 1'b0;
        if (m_mode == 1) begin
            if (m_cmd == C_FWD)   pat = 4'b1010;
            if (m_cmd == C_LEFT)  pat = 4'b1110;
            if (m_cmd == C_RIGHT) pat = 4'b1011;
            if (m_cmd != C_STOP)
                en = (m_pwm < ((m_cmd == C_FWD) ? DUTY_FWD : DUTY_TURN));
        end
        rdy = !reset && (m_mode == 0) && !proximity;
        return {rdy, m_mode != 0, m_mode == 2, en, en, pat};
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_mode = 0;
            m_pwm  = 0;
            return;
        end
        m_pwm = (m_pwm + 1) % 8;
        case (m_mode)
            0: if (cmd_valid && !proximity) begin
                m_mode = 1;
                m_cmd  = cmd;
                m_rem  = dur_of(cmd) - 1;
            end
            1: if (proximity) begin
                m_mode = 2;
                m_clr  = 0;
            end else if (m_rem == 0) begin
                m_mode = 0;
            end else begin
                m_rem = m_rem - 1;
            end
            default: if (proximity) m_clr = 0;
                     else if (m_clr == CLEAR_CYC - 1) m_mode = 1;
                     else m_clr = m_clr + 1;
        endcase
    endtask

    // Inputs change on the falling edge; caller samples at the next falling edge.
    task automatic cycle(input logic v, input logic [1:0] c, input logic p);
        cmd_valid = v;
        cmd       = c;
        proximity = p;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; proximity = 1'b0;
        #1 reset = 1'b1;
        m_mode = 0; m_pwm = 0; m_rem = 0; m_clr = 0; m_cmd = 2'b00;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (obs !== 9'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", obs, 9'b0);
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs, expect_vec());
        end
    endtask

    task automatic test_forward();
        int act = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(i == 0, C_FWD, 1'b0);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL forward cyc%0d: got %b want %b", i + 1, obs, expect_vec());
            end
            if (as2) act++;
        end
        total++;
        if (act !== DUR_FWD) begin
            bad++;
            $display("FAIL forward_len: got %0d want %0d", act, DUR_FWD);
        end
    endtask

    task automatic test_turns();
        logic [1:0] seq [2];
        int act;
        seq[0] = C_LEFT;
        seq[1] = C_RIGHT;
        for (int k = 0; k < 2; k++) begin
            act = 0;
            for (int i = 0; i < 8; i++) begin
                cycle(i == 0 || i == 3, (i == 3) ? C_STOP : seq[k], 1'b0);
                total++;
                if (obs !== expect_vec()) begin
                    bad++;
                    $display("FAIL turn%0d cyc%0d: got %b want %b", k, i + 1, obs, expect_vec());
                end
                if (as2) act++;
            end
            total++;
            if (act !== DUR_TURN) begin
                bad++;
                $display("FAIL turn%0d_len: got %0d want %0d", k, act, DUR_TURN);
            end
        end
    endtask

    task automatic test_block();
        for (int i = 0; i < 20; i++) begin
            cycle(i == 0, C_FWD, (i == 4 || i == 5));
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL block cyc%0d: got %b want %b", i + 1, obs, expect_vec());
            end
        end
    endtask

    task automatic test_block_toggle();
        logic [6:0] pat;
        pat = 7'b1001000;
        cycle(1'b1, C_RIGHT, 1'b0);
        cycle(1'b0, C_RIGHT, 1'b1);
        total++;
        if (blocked !== 1'b1) begin
            bad++;
            $display("FAIL toggle_enter: got %b want 1", blocked);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, C_LEFT, (i < 7) ? pat[6 - i] : 1'b0);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL toggle cyc%0d: got %b want %b", i, obs, expect_vec());
            end
        end
    endtask

    task automatic test_stop_idle();
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, C_STOP, 1'b0);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL stop cyc%0d: got %b want %b", i + 1, obs, expect_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, C_FWD, 1'b1);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL idle_prox cyc%0d: got %b want %b", i, obs, expect_vec());
            end
        end
        cycle(1'b0, C_FWD, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int act = 0;
        for (int i = 0; i < 3; i++) cycle(i == 0, C_FWD, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== 9'b0) begin
            bad++;
            $display("FAIL reset_async: got %b want %b", obs, 9'b0);
        end
        m_mode = 0;
        m_pwm  = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL reset_rel2: got %b want %b", obs, expect_vec());
        end
        for (int i = 0; i < 12; i++) begin
            cycle(i == 0, C_FWD, 1'b0);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL post_reset cyc%0d: got %b want %b", i + 1, obs, expect_vec());
            end
            if (as2) act++;
        end
        total++;
        if (act !== DUR_FWD) begin
            bad++;
            $display("FAIL post_reset_len: got %0d want %0d", act, DUR_FWD);
        end
    endtask

    task automatic test_random();
        logic       v, p;
        logic [1:0] c;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = 2'($urandom_range(0, 3));
            p = ($urandom_range(0, 9) < 2);
            cycle(v, c, p);
            total++;
            if (obs !== expect_vec()) begin
                bad++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs, expect_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_turns();
        test_block();
        test_block_toggle();
        test_stop_idle();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
